gate_arbiter: RTL and testbench

GATE_ARBITER -- requirements
Module: gate_arbiter

---
 rtl/gate_pkg.sv | 18 +
 rtl/gate_unit.sv | 28 ++
 rtl/gate_arbiter.sv | 90 +++++++++
 tb/tb_gate_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - opcode constants and response register state encoding
package gate_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/gate_unit.sv
// rtl/gate_unit.sv - shared combinational gate evaluator
module gate_unit
  import gate_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       out,
  output logic       err
);

  always_comb begin
    out = 1'b0;
    err = 1'b0;
    case (op)
      OP_NOT:  out = ~a;
      OP_AND:  out = a & b;
      OP_OR:   out = a | b;
      OP_NAND: out = ~(a & b);
      OP_NOR:  out = ~(a | b);
      OP_XOR:  out = a ^ b;
      OP_XNOR: out = ~(a ^ b);
      OP_ILL:  err = 1'b1;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - two-requester round-robin front end to a shared gate unit
module gate_arbiter
  import gate_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic       req0_a,
  input  logic       req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic       req1_a,
  input  logic       req1_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic       rsp_out,
  output logic       rsp_err,
  output logic [7:0] rsp_count
);

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant0, grant1, can_accept, accept;
  logic [2:0] sel_op;
  logic       sel_a, sel_b, gate_out, gate_err;

  assign rsp_valid  = (state == ST_FULL);
  assign can_accept = !rsp_valid || rsp_ready;

  // On contention the requester that did not win the last accepted transfer goes first.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0 && can_accept;
  assign req1_ready = grant1 && can_accept;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  gate_unit u_gate (
    .op  (sel_op),
    .a   (sel_a),
    .b   (sel_b),
    .out (gate_out),
    .err (gate_err)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (accept) state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_out    <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_count  <= 8'd0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        rsp_id     <= grant1;
        rsp_out    <= gate_out;
        rsp_err    <= gate_err;
        last_grant <= grant1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_count <= rsp_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_arbiter.sv
// tb/tb_gate_arbiter.sv - randomized and directed self-checking bench for gate_arbiter
module tb_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_out, rsp_err;
  logic [7:0] rsp_count;

  int errors = 0;
  int checks = 0;

  gate_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_err    (rsp_err),
    .rsp_count  (rsp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Truth table per opcode, indexed by {a,b}.
  function automatic logic truth(input int op, input logic a, input logic b);
    logic [3:0] t;
    case (op)
      0: t = 4'b0011;
      1: t = 4'b1000;
      2: t = 4'b1110;
      3: t = 4'b0111;
      4: t = 4'b0001;
      5: t = 4'b0110;
      6: t = 4'b1001;
      default: t = 4'b0000;
    endcase
    return t[{a, b}];
  endfunction

  // Reference model: held response plus arbitration history.
  logic       m_valid = 1'b0, m_id = 1'b0, m_out = 1'b0, m_err = 1'b0, m_last = 1'b1;
  logic [7:0] m_count = 8'd0;

  always @(negedge clk) begin
    logic g0, g1, e0, e1, ca;
    if (!rst_n) begin
      m_valid = 1'b0; m_id = 1'b0; m_out = 1'b0; m_err = 1'b0;
      m_count = 8'd0; m_last = 1'b1;
    end
    g0 = req0_valid && (!req1_valid || m_last == 1'b1);
    g1 = req1_valid && (!req0_valid || m_last == 1'b0);
    ca = !m_valid || rsp_ready;
    e0 = g0 && ca;
    e1 = g1 && ca;
    chk("model_req0_ready", req0_ready, e0);
    chk("model_req1_ready", req1_ready, e1);
    chk("model_rsp_valid", rsp_valid, m_valid);
    chk("model_rsp_count", rsp_count, m_count);
    if (m_valid || !rst_n) begin
      chk("model_rsp_id", rsp_id, m_id);
      chk("model_rsp_out", rsp_out, m_out);
      chk("model_rsp_err", rsp_err, m_err);
    end
    if (rst_n) begin
      if (m_valid && rsp_ready) m_count = m_count + 8'd1;
      if (e0 || e1) begin
        m_valid = 1'b1;
        m_id    = e1;
        m_last  = e1;
        m_err   = e1 ? (req1_op == 3'd7) : (req0_op == 3'd7);
        m_out   = e1 ? truth(int'(req1_op), req1_a, req1_b) : truth(int'(req0_op), req0_a, req0_b);
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic a, input logic b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] op, input logic a, input logic b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  logic acc0, acc1;

  initial begin
    rst_n = 1'b0;
    drive0(1'b0, 3'd0, 1'b0, 1'b0);
    drive1(1'b0, 3'd0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    #2;
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_count", rsp_count, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();

    // Single request
    drive0(1'b1, 3'd1, 1'b1, 1'b1);
    rsp_ready = 1'b1;
    step();
    req0_valid = 1'b0;
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_out", rsp_out, 1);
    chk("single_err", rsp_err, 0);
    step();
    chk("single_count", rsp_count, 1);

    // Exhaustive sweep via requester 1
    for (int op = 0; op < 7; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        drive1(1'b1, 3'(op), ab[1], ab[0]);
        step();
        req1_valid = 1'b0;
        chk("sweep_out", rsp_out, truth(op, ab[1], ab[0]));
        chk("sweep_id", rsp_id, 1);
      end
    end
    drive1(1'b1, 3'd5, 1'b1, 1'b0); step(); req1_valid = 1'b0; chk("xor_10", rsp_out, 1);
    drive1(1'b1, 3'd6, 1'b1, 1'b0); step(); req1_valid = 1'b0; chk("xnor_10", rsp_out, 0);
    drive1(1'b1, 3'd0, 1'b0, 1'b1); step(); req1_valid = 1'b0; chk("not_0", rsp_out, 1);

    // Contention alternates from reset
    do_reset();
    drive0(1'b1, 3'd1, 1'b1, 1'b0);
    drive1(1'b1, 3'd2, 1'b1, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("contend_id", rsp_id, i & 1);
      chk("contend_valid", rsp_valid, 1);
    end

    // Backpressure
    do_reset();
    drive0(1'b1, 3'd3, 1'b1, 1'b1);
    rsp_ready = 1'b0;
    step();
    drive0(1'b1, 3'd2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      chk("bp_out", rsp_out, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_count", rsp_count, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready0", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    chk("bp_new_out", rsp_out, 1);
    chk("bp_new_count", rsp_count, 1);

    // Illegal opcode
    drive0(1'b1, 3'd7, 1'b1, 1'b1);
    step();
    req0_valid = 1'b0;
    chk("ill_err", rsp_err, 1);
    chk("ill_out", rsp_out, 0);

    // Counter wrap
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 1; k <= 257; k++) begin
      drive0(1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      step();
      if (k == 256) chk("wrap_255", rsp_count, 255);
    end
    chk("wrap_0", rsp_count, 0);

    // Async reset while FULL
    step();
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    chk("pre_rst_count", rsp_count, 1);
    chk("pre_rst_valid", rsp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", rsp_valid, 0);
    chk("async_rst_count", rsp_count, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    drive0(1'b1, 3'd1, 1'b0, 1'b0);
    drive1(1'b1, 3'd1, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_ready0", req0_ready, 1);
    chk("post_rst_ready1", req1_ready, 0);
    step();
    chk("post_rst_id", rsp_id, 0);

    // Randomized traffic with held operands while stalled
    acc0 = 1'b1;
    acc1 = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!(req0_valid && !acc0)) drive0($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      else if ($urandom_range(0, 7) == 0) req0_valid = 1'b0;
      if (!(req1_valid && !acc1)) drive1($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      else if ($urandom_range(0, 7) == 0) req1_valid = 1'b0;
      rsp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
